// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared constants for the HI/LO multiply/divide unit.
// Holds the FSM state encodings, the bit positions inside the decoded
// MULT/DIV/MFHL/MTHL fields, and the fill bit used for LO on divide-by-zero.
package hilo_muldiv_unit_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  // Field bit positions: bit1 = unsigned variant / HI, bit0 = signed variant / LO
  localparam int FLD_U = 1;
  localparam int FLD_S = 0;

  // LO is filled with this bit on a zero divisor
  localparam logic DIV0_LO_BIT = 1'b1;

endpackage

// File: rtl/hilo_muldiv_unit_div_iter.sv
// Unsigned radix-2 restoring divider core, one quotient bit per cycle.
// Latency: i_start in cycle T, o_done (with final quotient/remainder) in T+WIDTH.
// Backpressure: none; the owner must not pulse i_start while a divide runs.
// Ports: clk, resetn | i_start, i_dividend, i_divisor | o_quotient, o_remainder, o_done
module hilo_muldiv_unit_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_done
);

  localparam int CW = $clog2(WIDTH);

  logic          r_run;
  logic [CW-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;  // dividend bits shift out of the top, quotient bits shift in
  logic [WIDTH-1:0] r_dvs;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_shift - {1'b0, r_dvs};
  assign w_ge      = ~w_diff[WIDTH];
  assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

  // Results are presented as next-state values so the owner can capture them
  // on the same edge that retires the last iteration.
  assign o_done      = r_run & (r_cnt == CW'(WIDTH - 1));
  assign o_quotient  = w_quo_nxt;
  assign o_remainder = w_rem_nxt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_run <= 1'b0;
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_dvs <= '0;
    end else if (i_start) begin
      r_run <= 1'b1;
      r_cnt <= '0;
      r_rem <= '0;
      r_quo <= i_dividend;
      r_dvs <= i_divisor;
    end else if (r_run) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (o_done) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// EX-stage HI/LO unit: mult[u], div[u], mthi/mtlo, mfhi/mflo.
// Latency: mult 2 cycles (busy 1), div WIDTH+1 cycles (busy WIDTH), mt 1, mf combinational.
// Backpressure: any HI/LO op while busy raises stall_req and is not accepted.
// Ports: clk, resetn | op_valid, flush, MULT, DIV, MFHL, MTHL, rs_value, rt_value
//        | hilo_rdata, busy, stall_req
module hilo_muldiv_unit
  import hilo_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid,
  input  logic             flush,
  input  logic [1:0]       MULT,
  input  logic [1:0]       DIV,
  input  logic [1:0]       MFHL,
  input  logic [1:0]       MTHL,
  input  logic [WIDTH-1:0] rs_value,
  input  logic [WIDTH-1:0] rt_value,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic             busy,
  output logic             stall_req
);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opa;     // multiplicand, or original dividend for the zero-divisor result
  logic [WIDTH-1:0] r_opb;
  logic             r_mul_sgn;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_dvz;

  logic             w_busy;
  logic             w_accept;
  logic             w_do_div;
  logic             w_do_mul;
  logic             w_do_mt;
  logic             w_div_sgn;
  logic             w_rs_neg;
  logic             w_rt_neg;
  logic [WIDTH-1:0] w_rs_abs;
  logic [WIDTH-1:0] w_rt_abs;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic             w_iter_done;
  logic             w_div_done;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_prod;

  assign w_busy    = (r_state != ST_IDLE);
  assign w_accept  = op_valid & ~flush & ~w_busy;
  // Malformed vectors resolve DIV > MULT > MTHL
  assign w_do_div  = w_accept & (|DIV);
  assign w_do_mul  = w_accept & ~(|DIV) & (|MULT);
  assign w_do_mt   = w_accept & ~(|DIV) & ~(|MULT) & (|MTHL);

  assign w_div_sgn = ~DIV[FLD_U];
  assign w_rs_neg  = w_div_sgn & rs_value[WIDTH-1];
  assign w_rt_neg  = w_div_sgn & rt_value[WIDTH-1];
  assign w_rs_abs  = w_rs_neg ? -rs_value : rs_value;
  assign w_rt_abs  = w_rt_neg ? -rt_value : rt_value;

  hilo_muldiv_unit_div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .clk         (clk),
    .resetn      (resetn),
    .i_start     (w_do_div),
    .i_dividend  (w_rs_abs),
    .i_divisor   (w_rt_abs),
    .o_quotient  (w_quo),
    .o_remainder (w_rem),
    .o_done      (w_iter_done)
  );

  assign w_div_done = (r_state == ST_DIV) & w_iter_done;
  // Truncating division: quotient sign is the XOR of operand signs, remainder follows dividend.
  // The most-negative / -1 case falls out naturally: |q| = 2^(W-1) negates to itself.
  assign w_q_fix = r_q_neg ? -w_quo : w_quo;
  assign w_r_fix = r_r_neg ? -w_rem : w_rem;

  // Sign- or zero-extend to 2*WIDTH so a single truncated multiply covers both forms
  assign w_a_ext = {{WIDTH{r_mul_sgn & r_opa[WIDTH-1]}}, r_opa};
  assign w_b_ext = {{WIDTH{r_mul_sgn & r_opb[WIDTH-1]}}, r_opb};
  assign w_prod  = w_a_ext * w_b_ext;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_opa     <= '0;
      r_opb     <= '0;
      r_mul_sgn <= 1'b0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_dvz     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_do_div || w_do_mul) begin
            r_opa     <= rs_value;
            r_opb     <= rt_value;
            r_mul_sgn <= ~MULT[FLD_U];
            r_q_neg   <= w_rs_neg ^ w_rt_neg;
            r_r_neg   <= w_rs_neg;
            r_dvz     <= (rt_value == '0);
            r_state   <= w_do_div ? ST_DIV : ST_MUL;
          end
        end
        ST_MUL:  r_state <= ST_IDLE;
        ST_DIV:  if (w_iter_done) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == ST_MUL) begin
      {r_hi, r_lo} <= w_prod;
    end else if (w_div_done) begin
      if (r_dvz) begin
        r_hi <= r_opa;
        r_lo <= {WIDTH{DIV0_LO_BIT}};
      end else begin
        r_hi <= w_r_fix;
        r_lo <= w_q_fix;
      end
    end else if (w_do_mt) begin
      if (MTHL[FLD_U]) r_hi <= rs_value;
      if (MTHL[FLD_S]) r_lo <= rs_value;
    end
  end

  assign hilo_rdata = MFHL[FLD_U] ? r_hi : (MFHL[FLD_S] ? r_lo : '0);
  assign busy       = w_busy;
  assign stall_req  = w_busy & op_valid & (|{MULT, DIV, MFHL, MTHL});

endmodule
